// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start/busy/done handshake
// plus the operand and result buses.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // Requester side: drives operands and start, observes status and result
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    // Subtractor side
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per clock,
// LSB first, through a single full-subtractor cell with a registered borrow.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sha_q, sha_d;
    logic [WIDTH-1:0]   shb_q, shb_d;
    // Holds the WIDTH-1 result bits produced so far; the last bit is merged on output
    logic [WIDTH-2:0]   shd_q, shd_d;
    logic               br_q, br_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;

    logic               x_bit, y_bit, d_bit, br_next;
    logic [WIDTH-1:0]   sh_cat;

    // Full-subtractor cell on the current LSBs
    always_comb begin
        x_bit   = sha_q[0];
        y_bit   = shb_q[0];
        d_bit   = x_bit ^ y_bit ^ br_q;
        br_next = (~x_bit & y_bit) | (~x_bit & br_q) | (y_bit & br_q);
        sh_cat  = {d_bit, shd_q};
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shd_d   = shd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    sha_d   = bus.a;
                    shb_d   = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                sha_d = sha_q >> 1;
                shb_d = shb_q >> 1;
                shd_d = sh_cat[WIDTH-1:1];
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    // Final bit: publish the whole word at once so partial shifts stay hidden
                    diff_d  = sh_cat;
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sha_q   <= '0;
            shb_q   <= '0;
            shd_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shd_q   <= shd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Status and result outputs
    always_comb begin
        bus.busy = (state_q == StShift);
        bus.done = (state_q == StDone);
        bus.diff = diff_q;
        bus.bout = bout_q;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes diff = a - b - bin one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow. This is the subtract-direction counterpart to the team's combinational full-adder cell, for area-constrained datapaths that can tolerate WIDTH-cycle latency. Operation is controlled by a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request: sample operands and begin; honoured only when busy=0
a  input  WIDTH  minuend, sampled on the accepted-start edge
b  input  WIDTH  subtrahend, sampled on the accepted-start edge
bin  input  1  borrow-in, sampled on the accepted-start edge
busy  output  1  high while the subtraction is in progress
done  output  1  one-cycle pulse; diff/bout valid from this cycle onward
diff  output  WIDTH  result a - b - bin mod 2^WIDTH
bout  output  1  final borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and bit counter are all cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: load shA<=a, shB<=b, br<=bin, cnt<=0, go to SHIFT.
- SHIFT (busy=1), each cycle:
  - Cell inputs are x=shA[0], y=shB[0], br.
  - d = x ^ y ^ br.
  - br_next = (~x & y) | (~x & br) | (y & br).
  - shA and shB shift right by 1.
  - d shifts into the MSB of the result shift register shD.
  - br <= br_next; cnt <= cnt+1.
  - On the cycle where cnt == WIDTH-1: go to DONE, diff <= shD-with-d-inserted, bout <= br_next.
- DONE:
  - busy=0, done=1 for exactly this cycle.
  - If start=1: accept new operands exactly as in IDLE and go to SHIFT. Otherwise go to IDLE.
- Latency:
  - Start accepted at edge 0; busy high from edge 0 to edge WIDTH.
  - done high for the cycle after edge WIDTH.
  - Throughput: one result per WIDTH+1 cycles when start is held.
- diff and bout:
  - Change only on the SHIFT->DONE transition; intermediate shift contents never appear on them.
  - Hold their value through IDLE and through the next operation until its DONE.
- start while busy=1: ignored; operands are not resampled and the operation is unaffected.
- a, b and bin may change freely after the accept edge.
- Counter width: $clog2(WIDTH), minimum 1 bit. Counter wrap is never reachable.
- Reset asserted mid-operation: immediately abort to the reset values. No done pulse, and the partial result is discarded.
- Arithmetic is unsigned modulo 2^WIDTH. Signed interpretation is the user's concern; bout is the unsigned borrow.

Test Plan:
1. WIDTH=8: a=0x5A, b=0x3C, bin=0, start pulse -> busy for 8 cycles, done pulse on cycle 9, diff=0x1E, bout=0.
2. WIDTH=8, underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
3. Start while busy: start with a=0x80, b=0x01; pulse start with a=0xFF, b=0xFF at cycle 3 -> diff=0x7F, bout=0, exactly one done pulse.
4. Back-to-back: hold start high with new operands (0x03-0x05) during the done cycle -> second op accepted with no IDLE cycle; diff=0xFE, bout=1 after a further 9 cycles; first result held until then.
5. Reset mid-op: assert rst_n=0 at cycle 4 of SHIFT -> busy/done/diff/bout=0 asynchronously; no done pulse; a following start completes correctly.
6. WIDTH=4 exhaustive: all a, b in 0..15 and bin in {0,1} -> {bout,diff} == (a - b - bin) in 5-bit two's complement, checked against a behavioural model.
